router_sync_n: RTL and testbench

// - Parametrised synchroniser between router FSM and NUM_CH output FIFOs.
// - Registers destination on header detect; steers write enable and full flag to that FIFO.
// - Produces per-channel valid (FIFO non-empty).
// - Per-channel read-timeout counters issue a one-cycle soft_reset when a valid output is not read in time.
// - Flags header addresses outside 0..NUM_CH-1.

---
 rtl/router_sync_n_pkg.sv | 20 ++
 rtl/router_sync_n_if.sv | 33 +++
 rtl/router_sync_n_timeout.sv | 33 +++
 rtl/router_sync_n.sv | 81 ++++++++
 tb/tb_router_sync_n.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/router_sync_n_pkg.sv
// Shared defaults and sizing helpers for the router synchroniser.
package router_sync_n_pkg;

  // Number of output channels and read-timeout length used by default
  localparam int NUM_CH_DEF  = 3;
  localparam int TIMEOUT_DEF = 30;

  // Bits needed to encode values 0..n-1 (never less than one bit)
  function automatic int addr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Address field width and timeout counter width derived from the defaults
  localparam int ADDR_W_DEF = addr_w(NUM_CH_DEF);
  localparam int CNT_W_DEF  = addr_w(TIMEOUT_DEF + 1);

endpackage

// File: rtl/router_sync_n_if.sv
// Handshake bundle between the router FSM / output FIFOs and the synchroniser.
interface router_sync_n_if
  import router_sync_n_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              addr_err;

  // FSM/FIFO side drives requests and status, observes the steering results
  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  vld_out, soft_reset, write_enb, fifo_full, addr_err
  );

  // Synchroniser side
  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output vld_out, soft_reset, write_enb, fifo_full, addr_err
  );

endinterface

// File: rtl/router_sync_n_timeout.sv
// Per-channel read timeout: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_sync_timeout #(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;

  // Count idle cycles, fire and re-arm on the TIMEOUT-th one
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!(vld && !rd)) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM and NUM_CH output FIFOs: latches the
// header destination, steers write enable / full flag, and times out unread data.
module router_sync_n
  import router_sync_n_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic           clock,
  input  logic           resetn,
  router_sync_n_if.slave bus
);

  logic [ADDR_W-1:0] dest_q;
  logic              dest_vld;
  logic              addr_ok;
  logic              addr_err_q;
  logic [NUM_CH-1:0] write_enb_c;
  logic              fifo_full_c;
  logic [NUM_CH-1:0] soft_reset_w;

  // Extra top bit keeps the compare correct when NUM_CH == 2**ADDR_W
  assign addr_ok = ({1'b0, bus.data_in} < (ADDR_W + 1)'(NUM_CH));

  // Latch destination on header; an out-of-range header invalidates it and flags an error
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dest_q     <= '0;
      dest_vld   <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      if (addr_ok) begin
        dest_q     <= bus.data_in;
        dest_vld   <= 1'b1;
        addr_err_q <= 1'b0;
      end else begin
        dest_vld   <= 1'b0;
        addr_err_q <= 1'b1;
      end
    end else begin
      addr_err_q <= 1'b0;
    end
  end

  // Write steering uses the registered destination; full uses the bypassed one
  always_comb begin
    write_enb_c = '0;
    fifo_full_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      write_enb_c[i] = bus.write_enb_reg && dest_vld && (dest_q == ADDR_W'(i));
      if (bus.detect_add) begin
        if (bus.data_in == ADDR_W'(i)) fifo_full_c = bus.full[i];
      end else if (dest_vld && (dest_q == ADDR_W'(i))) begin
        fifo_full_c = bus.full[i];
      end
    end
  end

  // One independent timeout counter per channel
  for (genvar g = 0; g < NUM_CH; g++) begin : g_timeout
    router_sync_timeout #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_timeout (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (~bus.empty[g]),
      .rd         (bus.read_enb[g]),
      .soft_reset (soft_reset_w[g])
    );
  end

  assign bus.vld_out    = ~bus.empty;
  assign bus.soft_reset = soft_reset_w;
  assign bus.write_enb  = write_enb_c;
  assign bus.fifo_full  = fifo_full_c;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n with NUM_CH=3, TIMEOUT=30.
module tb_router_sync_n;
  import router_sync_n_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  router_sync_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  router_sync_n #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Free-running 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with all FIFOs empty
    resetn            = 1'b0;
    bus.detect_add    = 1'b0;
    bus.data_in       = '0;
    bus.write_enb_reg = 1'b1;
    bus.read_enb      = '0;
    bus.empty         = 3'b111;
    bus.full          = 3'b111;
    next_cycle();
    next_cycle();
    check_output("rst_soft_reset", 8'(bus.soft_reset), 8'h0);
    check_output("rst_write_enb",  8'(bus.write_enb),  8'h0);
    check_output("rst_fifo_full",  8'(bus.fifo_full),  8'h0);
    check_output("rst_addr_err",   8'(bus.addr_err),   8'h0);
    check_output("rst_vld_out",    8'(bus.vld_out),    8'h0);

    // Header to channel 2: full visible in decode cycle, write steered next cycle
    resetn            = 1'b1;
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b100;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    #1;
    check_output("hdr2_fifo_full", 8'(bus.fifo_full), 8'h1);
    check_output("hdr2_write_enb", 8'(bus.write_enb), 8'h0);
    next_cycle();
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    check_output("pay2_write_enb", 8'(bus.write_enb), 8'h4);
    check_output("pay2_fifo_full", 8'(bus.fifo_full), 8'h1);
    check_output("pay2_addr_err",  8'(bus.addr_err),  8'h0);
    bus.full = 3'b001;
    #1;
    check_output("pay2_not_full", 8'(bus.fifo_full), 8'h0);

    // New header with concurrent write still steers to the old destination
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd0;
    #1;
    check_output("bypass_write_enb", 8'(bus.write_enb), 8'h4);
    check_output("bypass_fifo_full", 8'(bus.fifo_full), 8'h1);
    next_cycle();
    bus.detect_add = 1'b0;
    #1;
    check_output("pay0_write_enb", 8'(bus.write_enb), 8'h1);

    // Out-of-range header
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b111;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd3;
    #1;
    check_output("bad_hdr_fifo_full", 8'(bus.fifo_full), 8'h0);
    next_cycle();
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    check_output("bad_addr_err",  8'(bus.addr_err),  8'h1);
    check_output("bad_write_enb", 8'(bus.write_enb), 8'h0);
    check_output("bad_fifo_full", 8'(bus.fifo_full), 8'h0);
    next_cycle();
    check_output("bad_addr_err_clr", 8'(bus.addr_err), 8'h0);
    bus.write_enb_reg = 1'b0;

    // Channel 0 idle for 61 cycles: pulses in cycles 31 and 61
    bus.empty = 3'b110;
    #1;
    check_output("vld_out_ch0", 8'(bus.vld_out), 8'h1);
    for (int cyc = 1; cyc <= 61; cyc++) begin
      check_output($sformatf("idle61_c%0d", cyc), 8'(bus.soft_reset),
                   (cyc == 31 || cyc == 61) ? 8'h1 : 8'h0);
      if (cyc < 61) next_cycle();
    end
    bus.empty = 3'b111;
    next_cycle();

    // Read on cycle 30 restarts the count; pulse only after 30 more idle cycles
    bus.empty = 3'b110;
    for (int cyc = 1; cyc <= 61; cyc++) begin
      bus.read_enb = (cyc == 30) ? 3'b001 : 3'b000;
      #1;
      check_output($sformatf("rdreset_c%0d", cyc), 8'(bus.soft_reset),
                   (cyc == 61) ? 8'h1 : 8'h0);
      if (cyc < 61) next_cycle();
    end
    bus.read_enb = '0;
    bus.empty    = 3'b111;
    next_cycle();

    // Channels 0 and 1 idle, reset on cycle 21: both pulse 30 cycles after release
    bus.empty = 3'b100;
    for (int cyc = 1; cyc <= 55; cyc++) begin
      resetn = (cyc == 21) ? 1'b0 : 1'b1;
      #1;
      check_output($sformatf("midrst_c%0d", cyc), 8'(bus.soft_reset),
                   (cyc == 52) ? 8'h3 : 8'h0);
      if (cyc < 55) next_cycle();
    end
    resetn    = 1'b1;
    bus.empty = 3'b111;
    next_cycle();
    check_output("final_soft_reset", 8'(bus.soft_reset), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
